// File: rtl/prof_pkg.sv
// Shared types for the ap_ctrl_hs transaction profiler.
// One record per completed transaction: start stamp, latency, stall cycles.
package prof_pkg;

  localparam int CNT_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    WAIT_CONT,
    FINISHED
  } prof_state_t;

  typedef struct packed {
    logic [CNT_W-1:0] start;
    logic [CNT_W-1:0] latency;
    logic [CNT_W-1:0] stall;
  } prof_rec_t;

endpackage

// File: rtl/prof_fifo.sv
// Synchronous record FIFO; pointers carry an extra wrap bit.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module prof_fifo
  import prof_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      push,
  input  prof_rec_t din,
  input  logic      pop,
  output prof_rec_t dout,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);

  prof_rec_t mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic do_push;
  logic do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full = (wr_ptr[AW] != rd_ptr[AW]) &&
                (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/ap_ctrl_profiler.sv
// Taps an ap_ctrl_hs handshake, timestamps each transaction and queues
// latency/stall records for a valid/ready consumer.
module ap_ctrl_profiler #(
  parameter int CNT_W = 32,
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             finish,
  input  logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  input  logic             ap_continue,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [CNT_W-1:0] rec_start,
  output logic [CNT_W-1:0] rec_latency,
  output logic [CNT_W-1:0] rec_stall,
  output logic [CNT_W-1:0] txn_count,
  output logic [CNT_W-1:0] drop_count,
  output logic             overflow,
  output logic             busy,
  output logic             frozen
);

  import prof_pkg::*;

  prof_state_t state;
  prof_state_t state_n;

  logic [CNT_W-1:0] cyc;
  logic [CNT_W-1:0] t0;
  logic [CNT_W-1:0] lat;
  logic [CNT_W-1:0] stall;
  logic [CNT_W-1:0] t0_n;
  logic [CNT_W-1:0] lat_n;
  logic [CNT_W-1:0] stall_n;

  logic      complete;
  logic      pop;
  logic      drop;
  logic      fifo_full;
  logic      fifo_empty;
  prof_rec_t rec_in;
  prof_rec_t rec_out;

  // ap_ready is reserved for the pipelined-core variant
  logic unused_ready;
  assign unused_ready = ap_ready;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end

  always_comb begin
    state_n = state;
    t0_n = t0;
    lat_n = lat;
    stall_n = stall;
    complete = 1'b0;
    rec_in = '{start: t0, latency: lat, stall: stall};
    unique case (state)
      IDLE: begin
        if (ap_start) begin
          t0_n = cyc;
          if (!ap_done) begin
            state_n = BUSY;
          end else if (ap_continue) begin
            complete = 1'b1;
            rec_in = '{start: cyc, latency: '0, stall: '0};
          end else begin
            lat_n = '0;
            stall_n = CNT_W'(1);
            state_n = WAIT_CONT;
          end
        end
      end
      BUSY: begin
        if (ap_done) begin
          lat_n = cyc - t0;
          if (ap_continue) begin
            complete = 1'b1;
            rec_in = '{start: t0, latency: cyc - t0, stall: '0};
          end else begin
            stall_n = CNT_W'(1);
            state_n = WAIT_CONT;
          end
        end
      end
      WAIT_CONT: begin
        if (ap_continue) complete = 1'b1;
        else stall_n = stall + CNT_W'(1);
      end
      default: ;
    endcase
    // a zero-latency start in IDLE is consumed; it never re-arms BUSY
    if (complete && state != IDLE) begin
      if (ap_start) begin
        t0_n = cyc;
        state_n = BUSY;
      end else begin
        state_n = IDLE;
      end
    end
    if (finish && state != FINISHED) state_n = FINISHED;
  end

  always_comb begin
    busy = 1'b0;
    frozen = 1'b0;
    unique case (state)
      BUSY, WAIT_CONT: busy = 1'b1;
      FINISHED: frozen = 1'b1;
      default: ;
    endcase
  end

  assign rec_valid = !fifo_empty;
  assign pop = rec_valid && rec_ready;
  assign drop = complete && fifo_full && !pop;

  always_ff @(posedge clock) begin
    if (reset) begin
      cyc <= '0;
      t0 <= '0;
      lat <= '0;
      stall <= '0;
      txn_count <= '0;
      drop_count <= '0;
      overflow <= 1'b0;
    end else begin
      if (state != FINISHED) cyc <= cyc + CNT_W'(1);
      t0 <= t0_n;
      lat <= lat_n;
      stall <= stall_n;
      if (complete) txn_count <= txn_count + CNT_W'(1);
      if (drop) begin
        drop_count <= drop_count + CNT_W'(1);
        overflow <= 1'b1;
      end
    end
  end

  prof_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock(clock),
    .reset(reset),
    .push(complete),
    .din(rec_in),
    .pop(pop),
    .dout(rec_out),
    .full(fifo_full),
    .empty(fifo_empty)
  );

  assign rec_start = rec_out.start;
  assign rec_latency = rec_out.latency;
  assign rec_stall = rec_out.stall;

endmodule

// File: tb/tb_ap_ctrl_profiler.sv
// Directed bench for ap_ctrl_profiler.
// Inputs change on negedge; cycle index c equals the DUT cycle counter.
module tb_ap_ctrl_profiler;

  logic        clock = 1'b0;
  logic        reset;
  logic        finish;
  logic        ap_start;
  logic        ap_ready;
  logic        ap_done;
  logic        ap_continue;
  logic        rec_valid;
  logic        rec_ready;
  logic [31:0] rec_start;
  logic [31:0] rec_latency;
  logic [31:0] rec_stall;
  logic [31:0] txn_count;
  logic [31:0] drop_count;
  logic        overflow;
  logic        busy;
  logic        frozen;

  int checks = 0;
  int errors = 0;
  int c = 0;

  always #5 clock = ~clock;

  ap_ctrl_profiler #(
    .CNT_W(32),
    .DEPTH(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .finish(finish),
    .ap_start(ap_start),
    .ap_ready(ap_ready),
    .ap_done(ap_done),
    .ap_continue(ap_continue),
    .rec_valid(rec_valid),
    .rec_ready(rec_ready),
    .rec_start(rec_start),
    .rec_latency(rec_latency),
    .rec_stall(rec_stall),
    .txn_count(txn_count),
    .drop_count(drop_count),
    .overflow(overflow),
    .busy(busy),
    .frozen(frozen)
  );

  task automatic step();
    @(negedge clock);
    c++;
  endtask

  task automatic go(input int n);
    while (c < n) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    finish = 1'b0;
    ap_start = 1'b0;
    ap_ready = 1'b0;
    ap_done = 1'b0;
    ap_continue = 1'b1;
    rec_ready = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    c = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({rec_valid, busy, frozen, overflow} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got v/b/f/o=%b want 0000",
               {rec_valid, busy, frozen, overflow});
    end
    checks++;
    if ({txn_count, drop_count, rec_start, rec_latency, rec_stall} !== '0) begin
      errors++;
      $display("FAIL reset_counts: got txn=%0d drop=%0d s=%0d l=%0d st=%0d want 0",
               txn_count, drop_count, rec_start, rec_latency, rec_stall);
    end
  endtask

  task automatic test_basic();
    do_reset();
    go(5); ap_start = 1'b1;
    go(6); ap_start = 1'b0;
    go(8);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy: got %b want 1", busy);
    end
    go(12); ap_done = 1'b1;
    go(13); ap_done = 1'b0;
    checks++;
    if ({rec_valid, rec_start, rec_latency, rec_stall} !==
        {1'b1, 32'd5, 32'd7, 32'd0}) begin
      errors++;
      $display("FAIL basic_rec: got v=%b s=%0d l=%0d st=%0d want 1/5/7/0",
               rec_valid, rec_start, rec_latency, rec_stall);
    end
    checks++;
    if (txn_count !== 32'd1) begin
      errors++;
      $display("FAIL basic_txn: got %0d want 1", txn_count);
    end
  endtask

  task automatic test_zero_latency();
    do_reset();
    go(3); ap_start = 1'b1; ap_done = 1'b1;
    go(4); ap_start = 1'b0; ap_done = 1'b0;
    checks++;
    if ({rec_valid, busy, rec_start, rec_latency, rec_stall} !==
        {1'b1, 1'b0, 32'd3, 32'd0, 32'd0}) begin
      errors++;
      $display("FAIL zero_rec: got v=%b busy=%b s=%0d l=%0d st=%0d want 1/0/3/0/0",
               rec_valid, busy, rec_start, rec_latency, rec_stall);
    end
    checks++;
    if (txn_count !== 32'd1) begin
      errors++;
      $display("FAIL zero_txn: got %0d want 1", txn_count);
    end
  endtask

  task automatic test_stall();
    do_reset();
    go(10); ap_start = 1'b1;
    go(11); ap_start = 1'b0;
    go(20); ap_done = 1'b1; ap_continue = 1'b0;
    go(24); ap_continue = 1'b1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL stall_busy_hold: got %b want 1", busy);
    end
    go(25); ap_done = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL stall_busy_drop: got %b want 0", busy);
    end
    checks++;
    if ({rec_valid, rec_start, rec_latency, rec_stall} !==
        {1'b1, 32'd10, 32'd10, 32'd4}) begin
      errors++;
      $display("FAIL stall_rec: got v=%b s=%0d l=%0d st=%0d want 1/10/10/4",
               rec_valid, rec_start, rec_latency, rec_stall);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    go(2); ap_start = 1'b1;
    go(3); ap_start = 1'b0;
    go(8); ap_start = 1'b1; ap_done = 1'b1;
    go(9); ap_start = 1'b0; ap_done = 1'b0;
    go(14); ap_start = 1'b1; ap_done = 1'b1;
    go(15); ap_start = 1'b0; ap_done = 1'b0;
    go(20); ap_done = 1'b1;
    go(21); ap_done = 1'b0; rec_ready = 1'b1;
    checks++;
    if (txn_count !== 32'd3) begin
      errors++;
      $display("FAIL b2b_txn: got %0d want 3", txn_count);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({rec_valid, rec_start, rec_latency, rec_stall} !==
          {1'b1, 32'(2 + 6 * k), 32'd6, 32'd0}) begin
        errors++;
        $display("FAIL b2b_rec%0d: got v=%b s=%0d l=%0d st=%0d want 1/%0d/6/0",
                 k, rec_valid, rec_start, rec_latency, rec_stall, 2 + 6 * k);
      end
      step();
    end
    checks++;
    if (rec_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_empty: got %b want 0", rec_valid);
    end
    rec_ready = 1'b0;
  endtask

  task automatic test_overflow();
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      go(k); ap_start = 1'b1; ap_done = 1'b1;
      if (k == 10) begin
        checks++;
        if ({overflow, drop_count, txn_count} !== {1'b1, 32'd1, 32'd9}) begin
          errors++;
          $display("FAIL ovf_first: got o=%b drop=%0d txn=%0d want 1/1/9",
                   overflow, drop_count, txn_count);
        end
      end
    end
    go(11); ap_start = 1'b0; ap_done = 1'b0;
    checks++;
    if ({overflow, drop_count, txn_count} !== {1'b1, 32'd2, 32'd10}) begin
      errors++;
      $display("FAIL ovf_counts: got o=%b drop=%0d txn=%0d want 1/2/10",
               overflow, drop_count, txn_count);
    end
    go(12); rec_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      checks++;
      if ({rec_valid, rec_start} !== {1'b1, 32'(k)}) begin
        errors++;
        $display("FAIL ovf_drain%0d: got v=%b s=%0d want 1/%0d",
                 k, rec_valid, rec_start, k);
      end
      step();
    end
    checks++;
    if (rec_valid !== 1'b0) begin
      errors++;
      $display("FAIL ovf_empty: got %b want 0", rec_valid);
    end
    rec_ready = 1'b0;
  endtask

  task automatic test_full_pop();
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      go(k); ap_start = 1'b1; ap_done = 1'b1;
    end
    go(9); rec_ready = 1'b1;
    go(10); ap_start = 1'b0; ap_done = 1'b0;
    checks++;
    if ({overflow, drop_count, txn_count, rec_start} !==
        {1'b0, 32'd0, 32'd9, 32'd2}) begin
      errors++;
      $display("FAIL fullpop_state: got o=%b drop=%0d txn=%0d s=%0d want 0/0/9/2",
               overflow, drop_count, txn_count, rec_start);
    end
    go(17);
    checks++;
    if ({rec_valid, rec_start} !== {1'b1, 32'd9}) begin
      errors++;
      $display("FAIL fullpop_last: got v=%b s=%0d want 1/9", rec_valid, rec_start);
    end
    rec_ready = 1'b0;
  endtask

  task automatic test_finish();
    do_reset();
    go(3); ap_start = 1'b1;
    go(4); ap_start = 1'b0;
    go(6); finish = 1'b1;
    go(7); finish = 1'b0;
    checks++;
    if ({frozen, busy} !== 2'b10) begin
      errors++;
      $display("FAIL fin_state: got frozen=%b busy=%b want 1/0", frozen, busy);
    end
    go(8); ap_start = 1'b1; ap_done = 1'b1;
    go(9); ap_start = 1'b0; ap_done = 1'b0;
    go(10);
    checks++;
    if ({rec_valid, frozen, txn_count} !== {1'b0, 1'b1, 32'd0}) begin
      errors++;
      $display("FAIL fin_norec: got v=%b frozen=%b txn=%0d want 0/1/0",
               rec_valid, frozen, txn_count);
    end
  endtask

  task automatic test_finish_complete();
    do_reset();
    go(2); ap_start = 1'b1;
    go(3); ap_start = 1'b0;
    go(5); ap_done = 1'b1; finish = 1'b1;
    go(6); ap_done = 1'b0; finish = 1'b0;
    checks++;
    if ({frozen, rec_valid, rec_start, rec_latency, rec_stall, txn_count} !==
        {1'b1, 1'b1, 32'd2, 32'd3, 32'd0, 32'd1}) begin
      errors++;
      $display("FAIL fincomp_rec: got f=%b v=%b s=%0d l=%0d st=%0d txn=%0d want 1/1/2/3/0/1",
               frozen, rec_valid, rec_start, rec_latency, rec_stall, txn_count);
    end
    rec_ready = 1'b1;
    go(7);
    checks++;
    if (rec_valid !== 1'b0) begin
      errors++;
      $display("FAIL fincomp_drain: got %b want 0", rec_valid);
    end
    rec_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    go(1); ap_start = 1'b1; ap_done = 1'b1;
    go(2); ap_start = 1'b0; ap_done = 1'b0;
    go(3); ap_start = 1'b1;
    go(4); ap_start = 1'b0;
    go(5);
    checks++;
    if ({busy, rec_valid, txn_count} !== {1'b1, 1'b1, 32'd1}) begin
      errors++;
      $display("FAIL rmid_pre: got busy=%b v=%b txn=%0d want 1/1/1",
               busy, rec_valid, txn_count);
    end
    go(6); reset = 1'b1;
    step();
    checks++;
    if ({busy, frozen, rec_valid, overflow, txn_count, drop_count,
         rec_start, rec_latency, rec_stall} !== '0) begin
      errors++;
      $display("FAIL rmid_clear: got busy=%b f=%b v=%b o=%b txn=%0d drop=%0d s=%0d",
               busy, frozen, rec_valid, overflow, txn_count, drop_count, rec_start);
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_latency();
    test_stall();
    test_back_to_back();
    test_overflow();
    test_full_pop();
    test_finish();
    test_finish_complete();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ap_ctrl_profiler.md
# ap_ctrl_profiler

Synthesizable transaction profiler sitting directly downstream of an HLS ap_ctrl_hs core such as fetching_ip. It taps the core's ap_start/ap_ready/ap_done/ap_continue, timestamps each transaction, and pushes per-transaction latency records into a small FIFO drained by a valid/ready port. It gives on-chip runs the same per-module status data the simulation monitors dump to CSV.

## Interface
Parameters:
- CNT_W, 32: width of the cycle counter, timestamps, latency and stall fields.
- DEPTH, 8: record FIFO depth; must be a power of two, at least 2.

Ports:
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- finish  in  1  end of observation; freezes profiling.
- ap_start  in  1  tapped from the core.
- ap_ready  in  1  tapped from the core.
- ap_done  in  1  tapped from the core.
- ap_continue  in  1  tapped from the core; tie to 1 for cores without it.
- rec_valid  out  1  FIFO head valid.
- rec_ready  in  1  consumer accepts head.
- rec_start  out  CNT_W  cycle-count timestamp of transaction start.
- rec_latency  out  CNT_W  done cycle minus start cycle.
- rec_stall  out  CNT_W  cycles with ap_done=1 and ap_continue=0.
- txn_count  out  CNT_W  completed transactions, including dropped ones.
- drop_count  out  CNT_W  records lost to a full FIFO.
- overflow  out  1  sticky; set on first drop.
- busy  out  1  state is BUSY or WAIT_CONT.
- frozen  out  1  state is FINISHED.

## Operation
- Free-running `cyc` counter: 0 after reset, +1 per cycle, wraps modulo 2^CNT_W, holds in FINISHED. Latency subtraction is modulo 2^CNT_W, so a wrap inside a transaction still gives the correct latency.
- States: IDLE, BUSY, WAIT_CONT, FINISHED.
- IDLE, ap_start=1: capture `t0=cyc`.
  - ap_done=0: go to BUSY.
  - ap_done=1: zero-latency transaction; the done rules below apply in the same cycle.
- BUSY, ap_done=1: latch `lat=cyc-t0`.
  - ap_continue=1: complete and push the record.
  - ap_continue=0: go to WAIT_CONT with stall=1.
- WAIT_CONT: each cycle with ap_continue=0 adds 1 to stall. When ap_continue=1: complete, push, go to IDLE.
- Completion with ap_start=1 in the same cycle (back-to-back): `t0=cyc` and go to / stay in BUSY. Otherwise go to IDLE.
- Completion always increments txn_count.
- Push when the FIFO is full and not popping in that cycle: record dropped, drop_count+1, overflow=1.
- Push when the FIFO is full and popping in that cycle: push is accepted.
- finish=1 in any non-FINISHED state: go to FINISHED next cycle.
  - An in-flight transaction is discarded, with no record and no count.
  - A completion in the same cycle as finish still pushes.
- FINISHED is left only by reset. FIFO draining continues in FINISHED.
- ap_ready is not used for state tracking. It is reserved for the pipelined-core extension and is ignored in this version.

## Timing
- Reset values: rec_valid=0, all count and record outputs 0, overflow=0, busy=0, frozen=0, state IDLE. FIFO is emptied.
- A record pushed in cycle N gives rec_valid=1 in cycle N+1 at the earliest.
- Pop happens on rec_valid && rec_ready. The next head is presented the following cycle, so the drain rate is 1 record per cycle.
- rec_* outputs are held stable while rec_valid=1 and rec_ready=0.
- txn_count, drop_count and overflow update one cycle after the completion cycle.
- busy and frozen are registered state decodes.
- Reset mid-transaction: everything clears on the next edge; no record is emitted.

## Structure
- Package `prof_pkg`:
  - `prof_state_t` enum (IDLE, BUSY, WAIT_CONT, FINISHED).
  - `prof_rec_t` packed struct {start, latency, stall}, parameterized through a CNT_W localparam in the package.
- Sub-module `prof_fifo`:
  - synchronous FIFO of prof_rec_t, DEPTH entries.
  - pointers one bit wider than the index.
  - full/empty from pointer compare; simultaneous push and pop allowed when full.
- Top level holds the FSM, counters and drop logic.

## Test plan
- Reset release, then ap_start=1 at cyc=5, ap_done=1 at cyc=12, ap_continue=1 -> one record {start=5, latency=7, stall=0}; txn_count=1.
- ap_start and ap_done both 1 at cyc=3 -> record {3, 0, 0}; state stays IDLE.
- Done at cyc=20 with ap_continue low for 4 cycles -> stall=4; busy drops the cycle after ap_continue rises.
- Back-to-back: done and start in the same cycle, three transactions of 6 cycles each -> three records, latency 6 each, starts 6 apart.
- DEPTH=8, rec_ready=0, 10 completions -> 8 records kept, drop_count=2, overflow=1. Then rec_ready=1 drains 8 records in 8 consecutive cycles.
- finish=1 while BUSY -> frozen next cycle, no record, cyc held; reset mid-BUSY -> all outputs 0, rec_valid=0.
